mips_cpu_wb_stage: RTL and testbench

Registered, parametrised writeback stage for the MIPS CPU. It replaces the purely combinational register-write-data selector with a small sequential unit. It selects one of `NUM_SRC` result sources, or waits on a memory read with a bounded timeout. For memory loads it extracts and extends bytes/halfwords and merges LWL/LWR data. It then issues one registered write to the register file. It sits between the execute/memory logic and the register file write port.

---
 rtl/mips_cpu_wb_pkg.sv | 20 ++
 rtl/mips_cpu_wb_stage_if.sv | 36 +++
 rtl/mips_cpu_load_align.sv | 37 +++
 rtl/mips_cpu_wb_stage.sv | 153 +++++++++++++++
 tb/tb_mips_cpu_wb_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_wb_pkg.sv
// rtl/mips_cpu_wb_pkg.sv - shared types for the MIPS writeback stage
// Load-op encoding and FSM state type.
package mips_cpu_wb_pkg;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4,
    LD_WL = 3'd5,
    LD_WR = 3'd6
  } load_op_e;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mips_cpu_wb_stage_if.sv
// rtl/mips_cpu_wb_stage_if.sv - request, memory and register-file write bundle
// master drives requests and memory data; slave is the writeback stage.
interface mips_cpu_wb_stage_if #(
  parameter int NUM_SRC    = 4,
  parameter int REG_ADDR_W = 5
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_select;
  logic [NUM_SRC*32-1:0]   src_data;
  logic [REG_ADDR_W-1:0]   in_dest;
  logic [2:0]              in_load_op;
  logic [1:0]              in_byte_off;
  logic [31:0]             in_rt_old;
  logic [31:0]             mem_readdata;
  logic                    mem_rdvalid;
  logic                    wb_en;
  logic [REG_ADDR_W-1:0]   wb_addr;
  logic [31:0]             wb_data;
  logic                    timeout_err;

  modport master (
    output in_valid, in_select, src_data, in_dest, in_load_op, in_byte_off,
           in_rt_old, mem_readdata, mem_rdvalid,
    input  in_ready, wb_en, wb_addr, wb_data, timeout_err
  );

  modport slave (
    input  in_valid, in_select, src_data, in_dest, in_load_op, in_byte_off,
           in_rt_old, mem_readdata, mem_rdvalid,
    output in_ready, wb_en, wb_addr, wb_data, timeout_err
  );

endinterface

// File: rtl/mips_cpu_load_align.sv
// rtl/mips_cpu_load_align.sv - load data extraction, extension and LWL/LWR merge
// Purely combinational; reserved op codes pass the memory word through.
module mips_cpu_load_align
  import mips_cpu_wb_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_mem,
  input  logic [31:0] i_rt,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_lsh;
  logic [4:0]  w_rsh;

  assign w_byte = i_mem[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_mem[31:16] : i_mem[15:0];
  // LWL shifts left by 3-b bytes, LWR shifts right by b bytes
  assign w_lsh  = {~i_off, 3'b000};
  assign w_rsh  = {i_off, 3'b000};

  always_comb begin
    o_data = i_mem;
    case (i_op)
      LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_data = {24'd0, w_byte};
      LD_H:    o_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_data = {16'd0, w_half};
      LD_WL:   o_data = (i_mem << w_lsh) | (i_rt & ~(32'hFFFF_FFFF << w_lsh));
      LD_WR:   o_data = (i_mem >> w_rsh) | (i_rt & ~(32'hFFFF_FFFF >> w_rsh));
      default: o_data = i_mem;
    endcase
  end

endmodule

// File: rtl/mips_cpu_wb_stage.sv
// rtl/mips_cpu_wb_stage.sv - registered writeback stage with bounded memory wait
// Selects a result source or waits for load data, then issues one register-file write.
module mips_cpu_wb_stage
  import mips_cpu_wb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int MEM_SRC    = 1,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input logic                clk,
  input logic                reset,
  mips_cpu_wb_stage_if.slave bus
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SEL_W-1:0] MEM_SEL = SEL_W'(MEM_SRC);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [REG_ADDR_W-1:0] w_dest_nxt;
  logic [2:0]            r_op;
  logic [2:0]            w_op_nxt;
  logic [1:0]            r_off;
  logic [1:0]            w_off_nxt;
  logic [31:0]           r_rt;
  logic [31:0]           w_rt_nxt;

  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_addr;
  logic [31:0]           r_wb_data;
  logic                  r_timeout_err;

  logic                  w_wr_go;
  logic [REG_ADDR_W-1:0] w_wr_dest;
  logic [31:0]           w_wr_data;
  logic                  w_en_nxt;
  logic                  w_err_nxt;
  logic [31:0]           w_src_word;
  logic [31:0]           w_aligned;
  logic [2:0]            w_al_op;
  logic [1:0]            w_al_off;
  logic [31:0]           w_al_rt;

  assign w_src_word = bus.src_data[32*bus.in_select +: 32];

  // In IDLE the aligner sees the live request so a same-cycle load completes at once
  assign w_al_op  = (r_state == S_IDLE) ? bus.in_load_op  : r_op;
  assign w_al_off = (r_state == S_IDLE) ? bus.in_byte_off : r_off;
  assign w_al_rt  = (r_state == S_IDLE) ? bus.in_rt_old   : r_rt;

  mips_cpu_load_align u_align (
    .i_op   (w_al_op),
    .i_off  (w_al_off),
    .i_mem  (bus.mem_readdata),
    .i_rt   (w_al_rt),
    .o_data (w_aligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dest_nxt  = r_dest;
    w_op_nxt    = r_op;
    w_off_nxt   = r_off;
    w_rt_nxt    = r_rt;
    w_err_nxt   = 1'b0;
    w_wr_go     = 1'b0;
    w_wr_dest   = r_dest;
    w_wr_data   = w_aligned;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_select != MEM_SEL) begin
            w_wr_go   = 1'b1;
            w_wr_dest = bus.in_dest;
            w_wr_data = w_src_word;
          end else begin
            w_dest_nxt = bus.in_dest;
            w_op_nxt   = bus.in_load_op;
            w_off_nxt  = bus.in_byte_off;
            w_rt_nxt   = bus.in_rt_old;
            if (bus.mem_rdvalid) begin
              w_wr_go   = 1'b1;
              w_wr_dest = bus.in_dest;
            end else begin
              w_state_nxt = S_WAIT_MEM;
              w_cnt_nxt   = '0;
            end
          end
        end
      end
      S_WAIT_MEM: begin
        if (bus.mem_rdvalid) begin
          w_wr_go     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (TIMEOUT != 0 && w_cnt_nxt == TO_VAL) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_en_nxt = w_wr_go && (w_wr_dest != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_dest        <= '0;
      r_op          <= '0;
      r_off         <= '0;
      r_rt          <= '0;
      r_wb_en       <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_dest        <= w_dest_nxt;
      r_op          <= w_op_nxt;
      r_off         <= w_off_nxt;
      r_rt          <= w_rt_nxt;
      r_wb_en       <= w_en_nxt;
      r_timeout_err <= w_err_nxt;
      // Address/data only move with a strobe so they hold between writes
      if (w_en_nxt) begin
        r_wb_addr <= w_wr_dest;
        r_wb_data <= w_wr_data;
      end
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.wb_en       = r_wb_en;
  assign bus.wb_addr     = r_wb_addr;
  assign bus.wb_data     = r_wb_data;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mips_cpu_wb_stage.sv
// tb/tb_mips_cpu_wb_stage.sv - scoreboard bench for the writeback stage
// Directed requests push expected events; a negedge monitor pops and compares.
module tb_mips_cpu_wb_stage;
  import mips_cpu_wb_pkg::*;

  typedef struct {
    int          cyc;
    bit          err;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   nvec  = 0;
  int   nfail = 0;
  int   n0;
  exp_t q[$];

  mips_cpu_wb_stage_if #(.NUM_SRC(4), .REG_ADDR_W(5)) bus ();

  mips_cpu_wb_stage #(
    .NUM_SRC(4), .MEM_SRC(1), .REG_ADDR_W(5), .TIMEOUT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input int c, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.err = 1'b0; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic expect_err(input int c);
    exp_t e;
    e.cyc = c; e.err = 1'b1; e.addr = '0; e.data = '0;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] sel, input logic [4:0] dest, input logic [2:0] op,
                     input logic [1:0] off, input logic [31:0] rt, input logic [31:0] m,
                     input logic rdv);
    bus.in_valid     = 1'b1;
    bus.in_select    = sel;
    bus.in_dest      = dest;
    bus.in_load_op   = op;
    bus.in_byte_off  = off;
    bus.in_rt_old    = rt;
    bus.mem_readdata = m;
    bus.mem_rdvalid  = rdv;
    step();
    bus.in_valid     = 1'b0;
    bus.mem_rdvalid  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && (bus.wb_en || bus.timeout_err)) begin
      if (q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_event: cycle %0d wb_en=%0b timeout_err=%0b addr=%0d, required no event",
                 cyc, bus.wb_en, bus.timeout_err, bus.wb_addr);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_is_timeout", {31'd0, bus.timeout_err}, {31'd0, e.err});
        if (!e.err) begin
          chk("wb_addr", {27'd0, bus.wb_addr}, {27'd0, e.addr});
          chk("wb_data", bus.wb_data, e.data);
        end
      end
    end
  end

  // Same-cycle load vectors: op, offset, mem word, rt_old, expected result
  logic [2:0]  t_op [13] = '{LD_B, LD_BU, LD_B, LD_H, LD_HU, LD_H, 3'd7,
                             LD_WL, LD_WR, LD_WL, LD_WL, LD_WR, LD_WR};
  logic [1:0]  t_off[13] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2,
                             2'd1, 2'd1, 2'd3, 2'd0, 2'd3, 2'd0};
  logic [31:0] t_m  [13] = '{32'h80332211, 32'h80332211, 32'h80332211, 32'h80332211,
                             32'h80332211, 32'h80332211, 32'h80332211,
                             32'h44332211, 32'h44332211, 32'h44332211, 32'h44332211,
                             32'h44332211, 32'h44332211};
  logic [31:0] t_exp[13] = '{32'hFFFFFF80, 32'h00000080, 32'h00000022, 32'hFFFF8033,
                             32'h00008033, 32'h00002211, 32'h80332211,
                             32'h2211CCDD, 32'hAA443322, 32'h44332211, 32'h11BBCCDD,
                             32'hAABBCC44, 32'h44332211};

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_select    = '0;
    bus.src_data     = {32'hCAFEBABE, 32'h0BADF00D, 32'hDEADBEEF, 32'h12345678};
    bus.in_dest      = '0;
    bus.in_load_op   = '0;
    bus.in_byte_off  = '0;
    bus.in_rt_old    = '0;
    bus.mem_readdata = '0;
    bus.mem_rdvalid  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);
    chk("rst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    reset = 1'b0;

    // ALU result and back-to-back non-memory sources
    chk("alu_ready", {31'd0, bus.in_ready}, 32'd1);
    expect_wr(cyc + 1, 5'd8, 32'h12345678);
    req(2'd0, 5'd8, LD_W, 2'd0, 32'd0, 32'd0, 1'b0);
    expect_wr(cyc + 1, 5'd9, 32'h0BADF00D);
    req(2'd2, 5'd9, LD_W, 2'd0, 32'd0, 32'd0, 1'b0);
    expect_wr(cyc + 1, 5'd10, 32'hCAFEBABE);
    req(2'd3, 5'd10, LD_W, 2'd0, 32'd0, 32'd0, 1'b0);

    // LB with late data, arriving on the timeout-boundary cycle
    req(2'd1, 5'd5, LD_B, 2'd3, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("wait_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    chk("wait_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.mem_readdata = 32'h80332211;
    bus.mem_rdvalid  = 1'b1;
    expect_wr(cyc + 1, 5'd5, 32'hFFFFFF80);
    step();
    bus.mem_rdvalid = 1'b0;
    chk("ready_after_load", {31'd0, bus.in_ready}, 32'd1);

    // Same-cycle loads, one per cycle
    for (int i = 0; i < 13; i++) begin
      expect_wr(cyc + 1, 5'(16 + i), t_exp[i]);
      req(2'd1, 5'(16 + i), t_op[i], t_off[i], 32'hAABBCCDD, t_m[i], 1'b1);
    end

    // Timeout with no read data
    n0 = cyc;
    expect_err(n0 + 5);
    req(2'd1, 5'd11, LD_W, 2'd0, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      chk("timeout_wait_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    chk("timeout_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("timeout_cycle_ref", cyc, n0 + 5);

    // Destination 0 is consumed silently
    req(2'd3, 5'd0, LD_W, 2'd0, 32'd0, 32'd0, 1'b0);
    chk("r0_next_ready", {31'd0, bus.in_ready}, 32'd1);
    expect_wr(cyc + 1, 5'd12, 32'h12345678);
    req(2'd0, 5'd12, LD_W, 2'd0, 32'd0, 32'd0, 1'b0);

    // Reset while waiting on memory
    req(2'd1, 5'd13, LD_W, 2'd0, 32'd0, 32'd0, 1'b0);
    step();
    reset = 1'b1;
    #1;
    chk("midrst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    chk("midrst_wb_data", bus.wb_data, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    reset = 1'b0;
    bus.mem_readdata = 32'h77777777;
    bus.mem_rdvalid  = 1'b1;
    step();
    bus.mem_rdvalid = 1'b0;
    repeat (3) step();
    chk("postrst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    chk("postrst_wb_data", bus.wb_data, 32'd0);
    chk("postrst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int k = 0; k < 20 && q.size() != 0; k++) step();
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
